// File: rtl/me_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | me_pkg : shared constants, state encoding and helpers for me_top_module   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
package me_pkg;

  localparam int PIX_W    = 8;
  localparam int BLK      = 16;
  localparam int WIN      = 47;
  localparam int RANGE    = 32;
  localparam int SAD_W    = 16;
  localparam int ROWSAD_W = 12;

  localparam int BANK_PIX = 17;
  localparam int BANK_W   = BANK_PIX * PIX_W;
  localparam int ROW_W    = 3 * BANK_W;
  localparam int BLK_W    = BLK * PIX_W;

  localparam logic [7:0] BANK0_BASE = 8'd0;
  localparam logic [7:0] BANK1_BASE = 8'd47;
  localparam logic [7:0] BANK2_BASE = 8'd94;
  localparam logic [7:0] ADDR_LIMIT = 8'd141;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_WAIT   = 3'd2,
    ST_SEARCH = 3'd3,
    ST_DONE   = 3'd4
  } me_state_t;

  function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a,
                                                input logic [PIX_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage
`default_nettype wire

// File: rtl/me_sad_row16.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | me_sad_row16 : 16 absolute differences and adder tree, registered output  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module me_sad_row16
  import me_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [BLK_W-1:0]    cur_row,
  input  logic [BLK_W-1:0]    win_row,
  output logic [ROWSAD_W-1:0] row_sad
);

  logic [PIX_W-1:0]    w_ad [BLK];
  logic [PIX_W:0]      w_l1 [8];
  logic [PIX_W+1:0]    w_l2 [4];
  logic [PIX_W+2:0]    w_l3 [2];
  logic [ROWSAD_W-1:0] w_sum;

  generate
    for (genvar i = 0; i < BLK; i++) begin : g_ad
      assign w_ad[i] = abs_diff(cur_row[BLK_W-1-i*PIX_W -: PIX_W],
                                win_row[BLK_W-1-i*PIX_W -: PIX_W]);
    end
    for (genvar i = 0; i < 8; i++) begin : g_l1
      assign w_l1[i] = {1'b0, w_ad[2*i]} + {1'b0, w_ad[2*i+1]};
    end
    for (genvar i = 0; i < 4; i++) begin : g_l2
      assign w_l2[i] = {1'b0, w_l1[2*i]} + {1'b0, w_l1[2*i+1]};
    end
    for (genvar i = 0; i < 2; i++) begin : g_l3
      assign w_l3[i] = {1'b0, w_l2[2*i]} + {1'b0, w_l2[2*i+1]};
    end
  endgenerate

  assign w_sum = {1'b0, w_l3[0]} + {1'b0, w_l3[1]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_sad <= '0;
    end else begin
      row_sad <= w_sum;
    end
  end

endmodule
`default_nettype wire

// File: rtl/me_top_module.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | me_top_module : full-search 16x16 block-matching motion estimator         |
// | Optional early termination on `stop` when ME_EARLY_TERM_EN is defined.    |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module me_top_module
  import me_pkg::*;
#(
  parameter int START_DELAY = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [BLK_W-1:0]  CurrentBlock,
  input  logic              WE_S,
  input  logic              WE_S2,
  input  logic [7:0]        WADDR_S,
  input  logic [BANK_W-1:0] WDATA_S,
  output logic              DE_out,
  output logic [SAD_W-1:0]  outSAD41,
  output logic [9:0]        positionSAD41
);

  localparam int              TMR_W    = $clog2(START_DELAY + 1);
  localparam logic [TMR_W-1:0] LOAD_END = TMR_W'(BLK);
  localparam logic [TMR_W-1:0] ISSUE_AT = TMR_W'(START_DELAY - 1);
  localparam logic [13:0]     LAST_IDX = '1;
  localparam logic [9:0]      LAST_POS = '1;

  // ---------------- search window memory ----------------
  logic [BANK_W-1:0] bank0 [WIN];
  logic [BANK_W-1:0] bank1 [WIN];
  logic [BANK_W-1:0] bank2 [WIN];

  logic       w_wr01;
  logic [5:0] w_b0_addr;
  logic [5:0] w_b1_addr;
  logic [5:0] w_b2_addr;

  assign w_wr01    = WE_S & WE_S2;
  assign w_b0_addr = 6'(WADDR_S - BANK0_BASE);
  assign w_b1_addr = 6'(WADDR_S - BANK1_BASE);
  assign w_b2_addr = 6'(WADDR_S - BANK2_BASE);

  always_ff @(posedge clk) begin
    if (w_wr01 && (WADDR_S < BANK1_BASE)) begin
      bank0[w_b0_addr] <= WDATA_S;
    end
    if (w_wr01 && (WADDR_S >= BANK1_BASE) && (WADDR_S < BANK2_BASE)) begin
      bank1[w_b1_addr] <= WDATA_S;
    end
    if (WE_S && (WADDR_S >= BANK2_BASE) && (WADDR_S < ADDR_LIMIT)) begin
      bank2[w_b2_addr] <= WDATA_S;
    end
  end

  // ---------------- control state ----------------
  me_state_t           r_state;
  logic [TMR_W-1:0]    r_timer;
  logic [13:0]         r_idx;
  logic                r_issue_done;
  logic                r_s1_valid;
  logic                r_s1_first;
  logic                r_s1_last;
  logic [9:0]          r_s1_pos;
  logic                r_s2_valid;
  logic                r_s2_first;
  logic                r_s2_last;
  logic [9:0]          r_s2_pos;
  logic [SAD_W-1:0]    r_acc;
  logic [SAD_W-1:0]    r_best_sad;
  logic [9:0]          r_best_pos;
  logic                r_have_best;
  logic                r_fin;
  logic                r_publish;

  logic [BLK_W-1:0]    r_cur_blk [BLK];
  logic [BLK_W-1:0]    r_s1_win;
  logic [BLK_W-1:0]    r_s1_cur;
  logic [ROWSAD_W-1:0] w_row_sad;

  // Scan index is {y, x, row}: y outer, x inner, one block row per cycle.
  logic [4:0]       w_x;
  logic [4:0]       w_y;
  logic [3:0]       w_r;
  logic [5:0]       w_rd_row;
  logic [ROW_W-1:0] w_row;
  logic [8:0]       w_base;
  logic             w_stop;
  logic             w_issue;
  logic             w_ref_we;
  logic [3:0]       w_ref_idx;
  logic             w_accum;
  logic [SAD_W-1:0] w_cand;
  logic             w_better;

  assign {w_y, w_x, w_r} = r_idx;
  assign w_rd_row  = {1'b0, w_y} + {2'b00, w_r};
  assign w_row     = {bank0[w_rd_row], bank1[w_rd_row], bank2[w_rd_row]};
  assign w_base    = 9'(ROW_W - 1) - {1'b0, w_x, 3'b000};

`ifdef ME_EARLY_TERM_EN
  assign w_stop = stop && (r_state == ST_SEARCH);
`else
  logic w_unused_stop;
  assign w_unused_stop = stop;
  assign w_stop        = 1'b0;
`endif

  assign w_issue   = !start &&
                     (((r_state == ST_WAIT) && (r_timer == ISSUE_AT)) ||
                      ((r_state == ST_SEARCH) && !r_issue_done && !w_stop));
  assign w_ref_we  = !start && (r_state == ST_LOAD) && (r_timer != '0);
  assign w_ref_idx = 4'(r_timer - TMR_W'(1));
  assign w_accum   = r_s2_valid && !start && !w_stop;
  assign w_cand    = (r_s2_first ? '0 : r_acc) + SAD_W'(w_row_sad);
  assign w_better  = !r_have_best || (w_cand < r_best_sad);

  always_ff @(posedge clk) begin
    if (w_ref_we) begin
      r_cur_blk[w_ref_idx] <= CurrentBlock;
    end
    if (w_issue) begin
      r_s1_win <= w_row[w_base -: BLK_W];
      r_s1_cur <= r_cur_blk[w_r];
    end
  end

  me_sad_row16 u_sad_row (
    .clk     (clk),
    .rst     (rst),
    .cur_row (r_s1_cur),
    .win_row (r_s1_win),
    .row_sad (w_row_sad)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_timer       <= '0;
      r_idx         <= '0;
      r_issue_done  <= 1'b0;
      r_s1_valid    <= 1'b0;
      r_s1_first    <= 1'b0;
      r_s1_last     <= 1'b0;
      r_s1_pos      <= '0;
      r_s2_valid    <= 1'b0;
      r_s2_first    <= 1'b0;
      r_s2_last     <= 1'b0;
      r_s2_pos      <= '0;
      r_acc         <= '0;
      r_best_sad    <= '0;
      r_best_pos    <= '0;
      r_have_best   <= 1'b0;
      r_fin         <= 1'b0;
      r_publish     <= 1'b0;
      DE_out        <= 1'b0;
      outSAD41      <= '0;
      positionSAD41 <= '0;
    end else begin
      r_s1_valid <= w_issue;
      r_s2_valid <= r_s1_valid && !start && !w_stop;
      r_s2_first <= r_s1_first;
      r_s2_last  <= r_s1_last;
      r_s2_pos   <= r_s1_pos;
      if (w_issue) begin
        r_s1_first <= (w_r == 4'd0);
        r_s1_last  <= (w_r == 4'hF);
        r_s1_pos   <= {w_x, w_y};
      end

      // Strict less-than keeps the earliest candidate on ties.
      if (w_accum) begin
        r_acc <= w_cand;
        if (r_s2_last && w_better) begin
          r_best_sad  <= w_cand;
          r_best_pos  <= r_s2_pos;
          r_have_best <= 1'b1;
        end
        if (r_s2_last && (r_s2_pos == LAST_POS)) begin
          r_fin <= 1'b1;
        end
      end

      if (start) begin
        r_state      <= ST_LOAD;
        r_timer      <= '0;
        r_idx        <= '0;
        r_issue_done <= 1'b0;
        r_best_sad   <= '0;
        r_best_pos   <= '0;
        r_have_best  <= 1'b0;
        r_fin        <= 1'b0;
        r_publish    <= 1'b0;
        DE_out       <= 1'b0;
      end else begin
        case (r_state)
          ST_LOAD: begin
            r_timer <= r_timer + TMR_W'(1);
            if (r_timer == LOAD_END) begin
              r_state <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            r_timer <= r_timer + TMR_W'(1);
            if (r_timer == ISSUE_AT) begin
              r_state <= ST_SEARCH;
              r_idx   <= r_idx + 14'd1;
            end
          end
          ST_SEARCH: begin
            if (w_issue) begin
              r_idx <= r_idx + 14'd1;
              if (r_idx == LAST_IDX) begin
                r_issue_done <= 1'b1;
              end
            end
            if (w_stop) begin
              r_state   <= ST_DONE;
              r_publish <= 1'b1;
            end else if (r_fin) begin
              r_state       <= ST_DONE;
              r_fin         <= 1'b0;
              DE_out        <= 1'b1;
              outSAD41      <= r_best_sad;
              positionSAD41 <= r_best_pos;
            end
          end
          ST_DONE: begin
            // Early-terminated search publishes one cycle after entering DONE.
            if (r_publish) begin
              r_publish     <= 1'b0;
              DE_out        <= 1'b1;
              outSAD41      <= r_have_best ? r_best_sad : '1;
              positionSAD41 <= r_have_best ? r_best_pos : '0;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_me_top_module.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_me_top_module : directed self-checking bench for me_top_module         |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_me_top_module;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic [127:0] CurrentBlock = '0;
  logic         WE_S = 1'b0;
  logic         WE_S2 = 1'b0;
  logic [7:0]   WADDR_S = '0;
  logic [135:0] WDATA_S = '0;
  logic         DE_out;
  logic [15:0]  outSAD41;
  logic [9:0]   positionSAD41;

  me_top_module dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .stop          (stop),
    .CurrentBlock  (CurrentBlock),
    .WE_S          (WE_S),
    .WE_S2         (WE_S2),
    .WADDR_S       (WADDR_S),
    .WDATA_S       (WDATA_S),
    .DE_out        (DE_out),
    .outSAD41      (outSAD41),
    .positionSAD41 (positionSAD41)
  );

  always #5 clk = ~clk;

  int           n_checks = 0;
  int           n_fail = 0;
  logic [7:0]   win [47][51];
  logic [127:0] cur_blk [16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic logic [135:0] bank_word(input int row, input int b);
    logic [135:0] w;
    w = '0;
    for (int c = 0; c < 17; c++) w[135-8*c -: 8] = win[row][17*b+c];
    return w;
  endfunction

  task automatic wr(input int a, input logic [135:0] d, input logic we, input logic we2);
    @(negedge clk);
    WADDR_S = 8'(a); WDATA_S = d; WE_S = we; WE_S2 = we2;
    @(negedge clk);
    WE_S = 1'b0; WE_S2 = 1'b0;
  endtask

  task automatic load_window();
    for (int r = 0; r < 47; r++)
      for (int b = 0; b < 3; b++) wr(47*b + r, bank_word(r, b), 1'b1, 1'b1);
  endtask

  task automatic fill_random();
    for (int r = 0; r < 47; r++)
      for (int c = 0; c < 51; c++) win[r][c] = 8'($urandom);
  endtask

  task automatic cur_from_win(input int x, input int y);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) cur_blk[r][127-8*c -: 8] = win[y+r][x+c];
  endtask

  task automatic cur_const(input logic [7:0] v);
    for (int r = 0; r < 16; r++) cur_blk[r] = {16{v}};
  endtask

  // Pulses start, feeds rows 0..15 for edges S+2..S+17, optional stop sampled
  // at SEARCH cycle stop_at, and returns the edge count from S to DE_out.
  task automatic run_me(input int stop_at, output int lat);
    lat = -1;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 1; k <= 17000; k++) begin
      @(posedge clk); #1;
      if (k == 1) check("de_clear_after_start", 32'(DE_out), 32'd0);
      if (k <= 16) CurrentBlock = cur_blk[k-1];
      stop = (stop_at >= 0) && (k == 127 + stop_at);
      if (DE_out) begin
        lat = k;
        break;
      end
    end
    stop = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int stop4;

    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_de",  32'(DE_out), 32'd0);
    check("rst_sad", 32'(outSAD41), 32'd0);
    check("rst_pos", 32'(positionSAD41), 32'd0);
    @(negedge clk) rst = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    check("idle_de",  32'(DE_out), 32'd0);
    check("idle_sad", 32'(outSAD41), 32'd0);
    check("idle_pos", 32'(positionSAD41), 32'd0);

    // Exact match at x=7, y=20
    fill_random();
    load_window();
    cur_from_win(7, 20);
    run_me(-1, lat);
    check("m1_lat", 32'(lat), 32'd16514);
    check("m1_sad", 32'(outSAD41), 32'd0);
    check("m1_pos", 32'(positionSAD41), 32'({5'd7, 5'd20}));
    repeat (10) @(posedge clk);
    #1;
    check("m1_hold", 32'({DE_out, outSAD41, positionSAD41}), 32'({1'b1, 16'd0, 5'd7, 5'd20}));

    // Corner match x=31, y=31; bank2 rows restored with WE_S2=0 must be accepted
    fill_random();
    load_window();
    for (int r = 31; r < 47; r++) wr(94 + r, ~bank_word(r, 2), 1'b1, 1'b1);
    for (int r = 31; r < 47; r++) wr(94 + r, bank_word(r, 2), 1'b1, 1'b0);
    cur_from_win(31, 31);
    run_me(-1, lat);
    check("m2_lat", 32'(lat), 32'd16514);
    check("m2_sad", 32'(outSAD41), 32'd0);
    check("m2_pos", 32'(positionSAD41), 32'h3FF);

    // Uniform window: every candidate ties, earliest wins
    for (int r = 0; r < 47; r++)
      for (int c = 0; c < 51; c++) win[r][c] = 8'd0;
    load_window();
    cur_const(8'd10);
    run_me(-1, lat);
    check("u10_sad", 32'(outSAD41), 32'd2560);
    check("u10_pos", 32'(positionSAD41), 32'd0);

    // Maximum SAD; stop is pulsed here only when it must be ignored
`ifdef ME_EARLY_TERM_EN
    stop4 = -1;
`else
    stop4 = 100;
`endif
    cur_const(8'd255);
    run_me(stop4, lat);
    check("u255_lat", 32'(lat), 32'd16514);
    check("u255_sad", 32'(outSAD41), 32'd65280);
    check("u255_pos", 32'(positionSAD41), 32'd0);

    // Bank0/1 straddle at x=10, y=5; unqualified writes must be dropped
    fill_random();
    load_window();
    wr(47 + 8, ~bank_word(8, 1), 1'b1, 1'b0);
    wr(6, ~bank_word(6, 0), 1'b0, 1'b1);
    cur_from_win(10, 5);
    run_me(-1, lat);
    check("m5_lat", 32'(lat), 32'd16514);
    check("m5_sad", 32'(outSAD41), 32'd0);
    check("m5_pos", 32'(positionSAD41), 32'({5'd10, 5'd5}));

`ifdef ME_EARLY_TERM_EN
    // Column-ramp window, reference 20: candidate x=5,y=0 is best of 0..5
    for (int r = 0; r < 47; r++)
      for (int c = 0; c < 51; c++) win[r][c] = 8'(c);
    load_window();
    cur_const(8'd20);
    run_me(100, lat);
    check("et_lat", 32'(lat), 32'd229);
    check("et_sad", 32'(outSAD41), 32'd1920);
    check("et_pos", 32'(positionSAD41), 32'({5'd5, 5'd0}));
    run_me(5, lat);
    check("et0_lat", 32'(lat), 32'd134);
    check("et0_sad", 32'(outSAD41), 32'hFFFF);
    check("et0_pos", 32'(positionSAD41), 32'd0);
`endif

    // Reset in the middle of a search
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (300) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("mid_rst_de",  32'(DE_out), 32'd0);
    check("mid_rst_sad", 32'(outSAD41), 32'd0);
    check("mid_rst_pos", 32'(positionSAD41), 32'd0);
    @(negedge clk) rst = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("post_rst_de", 32'(DE_out), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
